fetch_prefetch_unit: RTL and testbench
======================================

Name: fetch_prefetch_unit

Overview:
- Read-side initiator for the unified `memory` block.
- Issues 4-word burst reads starting at a fetch PC and buffers the returned words with their PCs in an 8-entry prefetch FIFO.
- Presents the FIFO head, one instruction at a time, to the decode stage through a valid/stall handshake.
- Supports redirect (branch/jump) with flush of the FIFO and of any in-flight burst. Sits between the memory and the pipeline's decode stage.

Parameters:
- ADDR_WIDTH, 32, memory address width.
- DATA_WIDTH, 32, instruction/word width.
- START_ADDR, 32'h80020000, fetch PC after reset.
- BURST_CODE, 2'b01, access_size code driven on every request (01 = 4 words).
- BURST_LEN, 4, words returned per request; must match BURST_CODE.
- FIFO_DEPTH, 8, prefetch entries; power of two, at least BURST_LEN.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- mem_address  out  ADDR_WIDTH  burst start address, byte address, word aligned.
- mem_access_size  out  2  always BURST_CODE.
- mem_rw  out  1  1 = read; held at 1.
- mem_enable  out  1  request strobe, high for exactly one cycle per burst.
- mem_busy  in  1  memory not ready to accept a request.
- mem_data_out  in  DATA_WIDTH  read data from memory.
- stall  in  1  decode not ready; blocks the pop.
- redirect  in  1  flush and restart fetch.
- redirect_pc  in  ADDR_WIDTH  new fetch PC; bits [1:0] ignored (forced 0).
- insn  out  DATA_WIDTH  FIFO head instruction.
- insn_pc  out  ADDR_WIDTH  PC of insn.
- insn_valid  out  1  head valid.

Behaviour:
- Memory protocol: a request is sampled at posedge P0 when mem_enable=1 and mem_rw=1. Word k (k=0..3) of address+4k is valid on mem_data_out and is captured at posedge P(k+1).
- States:
  - IDLE → REQ when mem_busy=0 and the free-slot count is at least BURST_LEN. The free-slot count is FIFO_DEPTH minus occupancy, taking the same-cycle pop into account.
  - REQ: mem_enable=1 and mem_address=fetch_pc for one cycle → RECV.
  - RECV: capture one word per posedge and push {fetch_pc+4k, word}. After word 3, fetch_pc += 16 and return to IDLE.
  - DRAIN: discard the remaining in-flight words by count, then go to IDLE.
- Request rules:
  - Never assert mem_enable in RECV or DRAIN, or while mem_busy=1.
  - Back-to-back bursts are allowed: IDLE→REQ can happen in the cycle after the last word.
- Pop: the head is removed at a posedge where insn_valid=1 and stall=0. Push and pop in the same cycle are both performed.
- Outputs: insn, insn_pc and insn_valid are driven from registered FIFO state. insn_valid = !empty.
- Redirect (priority over push and pop):
  - At the posedge where redirect=1, the FIFO is emptied and fetch_pc = {redirect_pc[31:2], 2'b00}.
  - The state goes to DRAIN if a burst is in flight (REQ or RECV with words outstanding), otherwise to IDLE.
  - insn_valid is 0 in the following cycle.
  - A word arriving in the redirect cycle itself is discarded.
  - Redirect during DRAIN restarts with the newest redirect_pc; the drain count is unchanged.
- Arithmetic: fetch_pc and entry PCs are modulo 2^32; 32'hFFFFFFFC + 4 = 0. A burst may cross the wrap point.
- Full FIFO: the credit rule guarantees no push ever hits a full FIFO. An overflow is a design error, and the bench asserts it never occurs.
- Empty FIFO with stall=0: nothing is popped; insn_valid=0.
- Reset (asynchronous, any state, including mid-burst):
  - Immediately: mem_enable=0, mem_rw=1, mem_access_size=BURST_CODE, mem_address=START_ADDR, insn=0, insn_pc=0, insn_valid=0.
  - FIFO empty, state IDLE, fetch_pc=START_ADDR, drain count 0.
  - The memory is reset concurrently, so there is no drain after reset.
- Latency:
  - First mem_enable is in the first cycle after reset_n deasserts, provided mem_busy=0.
  - The first insn_valid rises in the cycle after P1, i.e. 3 cycles after reset release.
  - Steady state with stall=0: 4 instructions per 5 cycles.

Test Plan:
- Preload words 0x11111111, 0x22222222, … at 0x80020000; release reset with stall=0 → mem_enable pulses with addresses 80020000, 80020010, 80020020…; insn/insn_pc pairs arrive in order (11111111@80020000, 22222222@80020004, …); first valid 3 cycles after reset.
- Hold stall=1 → the FIFO holds 8 entries (insn_pc 80020000 at head) and mem_enable stays 0. Release stall → 8 entries pop in order on consecutive cycles with no duplicates or gaps, and the next request is at 80020020.
- Pulse redirect with redirect_pc=0x80020043 during word 1 of a burst → insn_valid=0 next cycle; the 2 remaining words are dropped; the next mem_address is 80020040; the first new insn_pc is 80020040.
- Force mem_busy=1 for 10 cycles while in IDLE with free slots → no mem_enable during those cycles; request is issued in the first cycle after mem_busy falls.
- Assert reset_n=0 asynchronously mid-RECV (between edges) → all outputs take reset values without waiting for a clock edge. After release, the first request is at 80020000 and no stale words are pushed.
- Redirect to 0xFFFFFFF8 → burst at FFFFFFF8; insn_pc sequence FFFFFFF8, FFFFFFFC, 00000000, 00000004; next request at 00000008.

Source files
------------

// File: rtl/fetch_prefetch_unit.sv
// Instruction prefetcher: issues 4-word burst reads, buffers {pc, word} pairs in a small FIFO
// and hands them one at a time to decode; redirect flushes the FIFO and drains any live burst.
module fetch_prefetch_unit #(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] START_ADDR = 32'h80020000,
   parameter logic [1:0]            BURST_CODE = 2'b01,
   parameter int                    BURST_LEN  = 4,
   parameter int                    FIFO_DEPTH = 8
) (
   input  logic                  clock,
   input  logic                  reset_n,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic [1:0]            mem_access_size,
   output logic                  mem_rw,
   output logic                  mem_enable,
   input  logic                  mem_busy,
   input  logic [DATA_WIDTH-1:0] mem_data_out,
   input  logic                  stall,
   input  logic                  redirect,
   input  logic [ADDR_WIDTH-1:0] redirect_pc,
   output logic [DATA_WIDTH-1:0] insn,
   output logic [ADDR_WIDTH-1:0] insn_pc,
   output logic                  insn_valid
);

   localparam int PTR_W   = $clog2(FIFO_DEPTH);
   localparam int CNT_W   = PTR_W + 1;
   localparam int BEAT_W  = $clog2(BURST_LEN);
   localparam int DRAIN_W = BEAT_W + 1;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_RECV, S_DRAIN} state_t;

   state_t                r_state, w_state_next;
   logic [ADDR_WIDTH-1:0] r_fetch_pc, w_fetch_pc_next;
   logic [BEAT_W-1:0]     r_beat, w_beat_next;
   logic [DRAIN_W-1:0]    r_drain, w_drain_next;

   logic [DATA_WIDTH-1:0] r_fifo_data [FIFO_DEPTH];
   logic [ADDR_WIDTH-1:0] r_fifo_pc   [FIFO_DEPTH];
   logic [PTR_W-1:0]      r_rd_ptr, r_wr_ptr;
   logic [CNT_W-1:0]      r_count;

   logic [CNT_W-1:0]      w_count_next;
   logic [ADDR_WIDTH-1:0] w_redirect_pc;
   logic [ADDR_WIDTH-1:0] w_push_pc;
   logic [FIFO_DEPTH-1:0] w_wr_sel;
   logic                  w_push, w_pop, w_req_fire, w_credit_ok, w_last_beat;

   assign w_push        = (r_state == S_RECV) && !redirect;
   assign w_pop         = (r_count != '0) && !stall && !redirect;
   assign w_count_next  = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
   // A new burst is only started when all of its words are guaranteed a slot.
   assign w_credit_ok   = (w_count_next <= CNT_W'(FIFO_DEPTH - BURST_LEN));
   assign w_req_fire    = (r_state == S_REQ) && !mem_busy;
   assign w_last_beat   = (r_beat == BEAT_W'(BURST_LEN - 1));
   assign w_redirect_pc = redirect_pc & ~ADDR_WIDTH'(3);
   assign w_push_pc     = r_fetch_pc + ADDR_WIDTH'({r_beat, 2'b00});

   always_comb begin
      w_state_next    = r_state;
      w_fetch_pc_next = r_fetch_pc;
      w_beat_next     = r_beat;
      w_drain_next    = r_drain;
      if (redirect) begin
         w_fetch_pc_next = w_redirect_pc;
         w_beat_next     = '0;
         w_state_next    = S_IDLE;
         w_drain_next    = '0;
         // Words still due after this edge must be swallowed before the next request.
         case (r_state)
            S_REQ: begin
               if (w_req_fire) begin
                  w_state_next = S_DRAIN;
                  w_drain_next = DRAIN_W'(BURST_LEN);
               end
            end
            S_RECV: begin
               if (!w_last_beat) begin
                  w_state_next = S_DRAIN;
                  w_drain_next = DRAIN_W'(BURST_LEN - 1) - DRAIN_W'(r_beat);
               end
            end
            S_DRAIN: begin
               if (r_drain > DRAIN_W'(1)) begin
                  w_state_next = S_DRAIN;
                  w_drain_next = r_drain - DRAIN_W'(1);
               end
            end
            default: ;
         endcase
      end else begin
         case (r_state)
            S_IDLE: begin
               if (!mem_busy && w_credit_ok) w_state_next = S_REQ;
            end
            S_REQ: begin
               if (w_req_fire) begin
                  w_state_next = S_RECV;
                  w_beat_next  = '0;
               end
            end
            S_RECV: begin
               w_beat_next = r_beat + BEAT_W'(1);
               if (w_last_beat) begin
                  w_beat_next     = '0;
                  w_fetch_pc_next = r_fetch_pc + ADDR_WIDTH'(4 * BURST_LEN);
                  w_state_next    = (!mem_busy && w_credit_ok) ? S_REQ : S_IDLE;
               end
            end
            S_DRAIN: begin
               w_drain_next = r_drain - DRAIN_W'(1);
               if (r_drain <= DRAIN_W'(1)) begin
                  w_state_next = S_IDLE;
                  w_drain_next = '0;
               end
            end
            default: w_state_next = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= S_IDLE;
         r_fetch_pc <= START_ADDR;
         r_beat     <= '0;
         r_drain    <= '0;
      end else begin
         r_state    <= w_state_next;
         r_fetch_pc <= w_fetch_pc_next;
         r_beat     <= w_beat_next;
         r_drain    <= w_drain_next;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else if (redirect) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         r_count <= w_count_next;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_wr_sel
         assign w_wr_sel[gi] = w_push && (r_wr_ptr == PTR_W'(gi));
      end
   endgenerate

   // Entries are reset so that insn/insn_pc read as zero straight out of reset.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            r_fifo_data[i] <= '0;
            r_fifo_pc[i]   <= '0;
         end
      end else begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (w_wr_sel[i]) begin
               r_fifo_data[i] <= mem_data_out;
               r_fifo_pc[i]   <= w_push_pc;
            end
         end
      end
   end

   assign mem_address     = r_fetch_pc;
   assign mem_access_size = BURST_CODE;
   assign mem_rw          = 1'b1;
   assign mem_enable      = w_req_fire;

   assign insn       = r_fifo_data[r_rd_ptr];
   assign insn_pc    = r_fifo_pc[r_rd_ptr];
   assign insn_valid = (r_count != '0);

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Randomised bench for fetch_prefetch_unit: a burst-memory model feeds the DUT and a scoreboard
// of expected {pc, word} pairs is checked against every instruction decode accepts.
module tb_fetch_prefetch_unit;

   localparam logic [31:0] START = 32'h80020000;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic [31:0] mem_address;
   logic [1:0]  mem_access_size;
   logic        mem_rw, mem_enable;
   logic        mem_busy = 1'b0;
   logic [31:0] mem_data_out = 32'h0;
   logic        stall = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic [31:0] insn, insn_pc;
   logic        insn_valid;

   always #5 clock = ~clock;

   fetch_prefetch_unit dut (
      .clock(clock), .reset_n(reset_n),
      .mem_address(mem_address), .mem_access_size(mem_access_size),
      .mem_rw(mem_rw), .mem_enable(mem_enable), .mem_busy(mem_busy),
      .mem_data_out(mem_data_out), .stall(stall), .redirect(redirect),
      .redirect_pc(redirect_pc), .insn(insn), .insn_pc(insn_pc),
      .insn_valid(insn_valid)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Preloaded memory image: 0x11111111, 0x22222222, ... starting at START.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (((a - START) >> 2) + 32'd1) * 32'h11111111;
   endfunction

   typedef struct {
      logic [31:0] pc;
      logic [31:0] w;
   } exp_t;
   typedef struct {
      logic [31:0] addr;
      int          epoch;
      int          k;
   } beat_t;

   exp_t        exp_q[$];
   beat_t       dq[$];
   beat_t       cur;
   bit          cur_v = 0;
   int          epoch = 0;
   int          occ = 0;
   int          pop_cnt = 0;
   logic [31:0] exp_req_pc = START;

   logic        s_en, s_valid, s_stall, s_redir;
   logic [31:0] s_addr, s_rpc;

   always @(negedge clock) begin
      s_en    = mem_enable;
      s_addr  = mem_address;
      s_valid = insn_valid;
      s_stall = stall;
      s_redir = redirect;
      s_rpc   = redirect_pc;
   end

   // Memory + expected-stream model, advanced once per rising edge from pre-edge snapshots.
   always @(posedge clock) begin
      if (!reset_n) begin
         dq.delete();
         exp_q.delete();
         cur_v = 0;
         occ = 0;
         epoch++;
         exp_req_pc = START;
      end else begin
         if (cur_v && cur.epoch == epoch && !s_redir) begin
            occ++;
            check("fifo_no_overflow", occ <= 8, 1);
         end
         if (s_valid && !s_stall && !s_redir) begin
            occ--;
            pop_cnt++;
         end
         if (s_en) begin
            check("req_addr", s_addr, exp_req_pc);
            for (int k = 0; k < 4; k++) begin
               dq.push_back('{s_addr + 32'(4 * k), epoch, k});
               exp_q.push_back('{exp_req_pc + 32'(4 * k), mem_word(exp_req_pc + 32'(4 * k))});
            end
            exp_req_pc += 32'd16;
         end
         if (s_redir) begin
            epoch++;
            occ = 0;
            exp_q.delete();
            exp_req_pc = s_rpc & ~32'd3;
         end
         if (dq.size() > 0) begin
            cur = dq.pop_front();
            cur_v = 1;
         end else begin
            cur_v = 0;
         end
      end
   end

   always @(negedge clock) mem_data_out = cur_v ? mem_word(cur.addr) : 32'h0;

   // Scoreboard monitor: every accepted instruction is compared against the expected stream.
   always @(negedge clock) begin
      exp_t e;
      if (reset_n) begin
         check("valid_vs_occupancy", insn_valid, occ > 0);
         if (mem_enable) begin
            check("enable_while_busy", mem_busy, 0);
            check("mem_rw", mem_rw, 1);
            check("access_size", mem_access_size, 2'b01);
         end
         if (insn_valid && !stall && !redirect) begin
            if (exp_q.size() == 0) begin
               check("pop_without_expected", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("insn_pc", insn_pc, e.pc);
               check("insn", insn, e.w);
            end
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic wait_en(input int maxc, output bit ok);
      ok = 0;
      for (int i = 0; i < maxc; i++) begin
         @(negedge clock);
         if (mem_enable) begin
            ok = 1;
            break;
         end
      end
   endtask

   task automatic wait_beat(input int k, input int maxc, output bit ok);
      ok = 0;
      for (int i = 0; i < maxc; i++) begin
         @(posedge clock);
         #1;
         if (cur_v && cur.epoch == epoch && cur.k == k) begin
            ok = 1;
            break;
         end
      end
   endtask

   task automatic do_redirect(input logic [31:0] pc);
      redirect = 1'b1;
      redirect_pc = pc;
      cyc(1);
      redirect = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_enable"}, mem_enable, 0);
      check({tag, "_rw"}, mem_rw, 1);
      check({tag, "_size"}, mem_access_size, 2'b01);
      check({tag, "_address"}, mem_address, START);
      check({tag, "_insn"}, insn, 0);
      check({tag, "_insn_pc"}, insn_pc, 0);
      check({tag, "_valid"}, insn_valid, 0);
   endtask

   initial begin
      int  first_en, first_v, p0, n;
      bit  ok;
      int  en_seen;

      cyc(2);
      check_reset_outputs("reset");

      // Latency from reset release.
      reset_n = 1'b1;
      first_en = 0;
      first_v = 0;
      for (int c = 1; c <= 6; c++) begin
         @(posedge clock);
         @(negedge clock);
         if (mem_enable && first_en == 0) first_en = c;
         if (insn_valid && first_v == 0) begin
            first_v = c;
            check("first_insn", insn, 32'h11111111);
            check("first_insn_pc", insn_pc, START);
         end
      end
      check("first_enable_cycle", first_en, 1);
      check("first_valid_cycle", first_v, 3);

      // Steady-state throughput with no stall.
      cyc(10);
      p0 = pop_cnt;
      cyc(50);
      check("throughput_4_per_5", (pop_cnt - p0 >= 38) && (pop_cnt - p0 <= 42), 1);

      // Fill the FIFO from a known point under stall, then release.
      stall = 1'b1;
      do_redirect(START);
      cyc(20);
      en_seen = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clock);
         if (mem_enable) en_seen++;
      end
      check("no_request_when_full", en_seen, 0);
      check("full_head_valid", insn_valid, 1);
      check("full_head_pc", insn_pc, 32'h80020000);
      cyc(1);
      stall = 1'b0;
      wait_en(20, ok);
      check("wait_req_after_full", ok, 1);
      check("req_after_full_addr", mem_address, 32'h80020020);

      // Redirect while word 1 of a burst is on the bus.
      wait_beat(1, 40, ok);
      check("wait_word1", ok, 1);
      do_redirect(32'h80020043);
      check("valid_after_redirect", insn_valid, 0);
      wait_en(20, ok);
      check("wait_req_after_redirect", ok, 1);
      check("req_after_redirect_addr", mem_address, 32'h80020040);
      n = 0;
      for (int i = 0; i < 20 && !insn_valid; i++) @(negedge clock);
      check("first_pc_after_redirect", insn_pc, 32'h80020040);

      // mem_busy holds off a request in IDLE with free slots.
      cyc(1);
      stall = 1'b1;
      cyc(20);
      mem_busy = 1'b1;
      stall = 1'b0;
      en_seen = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         if (mem_enable) en_seen++;
      end
      check("no_request_while_busy", en_seen, 0);
      cyc(1);
      mem_busy = 1'b0;
      n = 0;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clock);
         if (mem_enable) begin
            n = i;
            break;
         end
      end
      check("busy_release_latency", n, 2);

      // Asynchronous reset in the middle of a burst.
      wait_beat(1, 40, ok);
      check("wait_word1_for_reset", ok, 1);
      #2;
      reset_n = 1'b0;
      #1;
      check_reset_outputs("async_reset");
      cyc(2);
      reset_n = 1'b1;
      wait_en(10, ok);
      check("wait_req_after_reset", ok, 1);
      check("req_after_reset_addr", mem_address, START);

      // Burst that wraps the address space.
      cyc(12);
      do_redirect(32'hFFFFFFF8);
      wait_en(20, ok);
      check("wait_wrap_req", ok, 1);
      check("wrap_req_addr", mem_address, 32'hFFFFFFF8);
      cyc(1);
      wait_en(20, ok);
      check("wait_post_wrap_req", ok, 1);
      check("post_wrap_req_addr", mem_address, 32'h00000008);

      // Randomised traffic.
      for (int i = 0; i < 2000; i++) begin
         cyc(1);
         stall    = ($urandom_range(0, 99) < 30);
         mem_busy = ($urandom_range(0, 99) < 15);
         redirect = ($urandom_range(0, 99) < 3);
         case ($urandom_range(0, 2))
            0: redirect_pc = $urandom;
            1: redirect_pc = 32'hFFFFFFF0 + 32'($urandom_range(0, 15));
            default: redirect_pc = START + 32'($urandom_range(0, 255));
         endcase
      end
      cyc(1);
      stall = 1'b0;
      mem_busy = 1'b0;
      redirect = 1'b0;
      cyc(40);
      check("stream_still_flowing", pop_cnt > p0 + 100, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

endmodule
